// File: rtl/task_pkg.sv
// Shared types and width helpers for the task queue producer and distributor.
// Lane FSM encoding is used only when TASK_ENQUEUE_MERGE_EN is defined.
package task_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StHoldPush,
    StHoldPop
  } lane_state_e;

  function automatic int unsigned tree_bits(int unsigned tree_num);
    return (tree_num > 1) ? $clog2(tree_num) : 1;
  endfunction

  function automatic int unsigned data_bits(int unsigned ptw, int unsigned mtw,
                                            int unsigned plw);
    return ptw + mtw + plw;
  endfunction

  function automatic int unsigned task_bits(int unsigned ptw, int unsigned mtw,
                                            int unsigned plw, int unsigned tree_num);
    return data_bits(ptw, mtw, plw) + 2 * tree_bits(tree_num) + 2;
  endfunction

  function automatic int unsigned cnt_bits(int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  // Task word field positions, LSB-relative: {push, pop, push_tree, pop_tree, data}
  function automatic int unsigned push_bit_pos(int unsigned tb);
    return tb - 1;
  endfunction

  function automatic int unsigned pop_bit_pos(int unsigned tb);
    return tb - 2;
  endfunction

  function automatic int unsigned push_tree_lsb(int unsigned db, int unsigned trb);
    return db + trb;
  endfunction

  function automatic int unsigned pop_tree_lsb(int unsigned db);
    return db;
  endfunction

endpackage

// File: rtl/task_enqueue_lane.sv
// One task queue lane: request packing (optional push/pop merge FSM) and task FIFO.
// Merging is compiled in with TASK_ENQUEUE_MERGE_EN.
module task_enqueue_lane
  import task_pkg::*;
#(
  parameter int unsigned DataBits  = 40,
  parameter int unsigned TreeBits  = 2,
  parameter int unsigned Depth     = 16,
  parameter int unsigned MergeWait = 4,
  parameter int unsigned TaskBits  = DataBits + 2 * TreeBits + 2,
  parameter int unsigned CntBits   = $clog2(Depth) + 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                push_valid_i,
  output logic                push_ready_o,
  input  logic [TreeBits-1:0] push_tree_i,
  input  logic [DataBits-1:0] push_data_i,
  input  logic                pop_valid_i,
  output logic                pop_ready_o,
  input  logic [TreeBits-1:0] pop_tree_i,
  input  logic                task_pop_i,
  output logic [TaskBits-1:0] task_data_o,
  output logic                task_empty_o,
  output logic [CntBits-1:0]  task_count_o
);

  localparam int unsigned PtrBits = $clog2(Depth);
  localparam logic [TreeBits-1:0] NoTree = '0;
  localparam logic [DataBits-1:0] NoData = '0;

  logic [TaskBits-1:0] mem_q [Depth];
  logic [PtrBits-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntBits-1:0]  count_q, count_d;
  logic [TaskBits-1:0] task_data_q, task_data_d;
  logic                can_wr, wr_en, rd_en;
  logic [TaskBits-1:0] wr_word;

  // Space is judged on the registered count; a same-cycle read frees nothing.
  assign can_wr = !rst_i && (count_q < CntBits'(Depth));
  assign rd_en  = task_pop_i && (count_q != '0);

`ifdef TASK_ENQUEUE_MERGE_EN
  localparam logic [7:0] HoldLast = 8'(MergeWait - 1);

  lane_state_e         state_q, state_d;
  logic [7:0]          timer_q, timer_d;
  logic [TreeBits-1:0] held_tree_q, held_tree_d;
  logic [DataBits-1:0] held_data_q, held_data_d;

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    held_tree_d  = held_tree_q;
    held_data_d  = held_data_q;
    push_ready_o = 1'b0;
    pop_ready_o  = 1'b0;
    wr_en        = 1'b0;
    wr_word      = '0;
    unique case (state_q)
      StIdle: begin
        push_ready_o = can_wr;
        pop_ready_o  = can_wr;
        if (can_wr && push_valid_i && pop_valid_i) begin
          wr_en   = 1'b1;
          wr_word = {2'b11, push_tree_i, pop_tree_i, push_data_i};
        end else if (can_wr && push_valid_i) begin
          state_d     = StHoldPush;
          timer_d     = '0;
          held_tree_d = push_tree_i;
          held_data_d = push_data_i;
        end else if (can_wr && pop_valid_i) begin
          state_d     = StHoldPop;
          timer_d     = '0;
          held_tree_d = pop_tree_i;
          held_data_d = '0;
        end
      end
      StHoldPush: begin
        pop_ready_o = can_wr;
        if (can_wr && pop_valid_i) begin
          wr_en   = 1'b1;
          wr_word = {2'b11, held_tree_q, pop_tree_i, held_data_q};
          state_d = StIdle;
        end else if (timer_q != HoldLast) begin
          timer_d = timer_q + 1'b1;
        end else if (can_wr) begin
          wr_en   = 1'b1;
          wr_word = {2'b10, held_tree_q, NoTree, held_data_q};
          state_d = StIdle;
        end
      end
      StHoldPop: begin
        push_ready_o = can_wr;
        if (can_wr && push_valid_i) begin
          wr_en   = 1'b1;
          wr_word = {2'b11, push_tree_i, held_tree_q, push_data_i};
          state_d = StIdle;
        end else if (timer_q != HoldLast) begin
          timer_d = timer_q + 1'b1;
        end else if (can_wr) begin
          wr_en   = 1'b1;
          wr_word = {2'b01, NoTree, held_tree_q, NoData};
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      timer_q     <= '0;
      held_tree_q <= '0;
      held_data_q <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      held_tree_q <= held_tree_d;
      held_data_q <= held_data_d;
    end
  end
`else
  // Push wins a same-cycle collision; the pop is taken on a later cycle.
  always_comb begin
    push_ready_o = can_wr;
    pop_ready_o  = can_wr && !push_valid_i;
    wr_en        = 1'b0;
    wr_word      = '0;
    if (can_wr && push_valid_i) begin
      wr_en   = 1'b1;
      wr_word = {2'b10, push_tree_i, NoTree, push_data_i};
    end else if (can_wr && pop_valid_i) begin
      wr_en   = 1'b1;
      wr_word = {2'b01, NoTree, pop_tree_i, NoData};
    end
  end
`endif

  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    task_data_d = task_data_q;
    if (wr_en) wptr_d = wptr_q + 1'b1;
    if (rd_en) begin
      rptr_d      = rptr_q + 1'b1;
      task_data_d = mem_q[rptr_q];
    end
    if (wr_en && !rd_en) begin
      count_d = count_q + 1'b1;
    end else if (!wr_en && rd_en) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wptr_q] <= wr_word;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      task_data_q <= '0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      task_data_q <= task_data_d;
    end
  end

  assign task_data_o  = task_data_q;
  assign task_empty_o = (count_q == '0);
  assign task_count_o = count_q;

endmodule

// File: rtl/task_enqueue.sv
// Producer side of the per-RPU task queues: LEVEL independent lanes.
// Define TASK_ENQUEUE_MERGE_EN to combine nearby push/pop requests into PP words.
module task_enqueue
  import task_pkg::*;
#(
  parameter int unsigned PTW        = 16,
  parameter int unsigned MTW        = 16,
  parameter int unsigned PLW        = 8,
  parameter int unsigned LEVEL      = 4,
  parameter int unsigned TREE_NUM   = 4,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned MERGE_WAIT = 4
) (
  input  logic                                          i_clk,
  input  logic                                          i_rst,
  input  logic [LEVEL-1:0]                              i_push_valid,
  output logic [LEVEL-1:0]                              o_push_ready,
  input  logic [tree_bits(TREE_NUM)-1:0]                i_push_treeId [0:LEVEL-1],
  input  logic [data_bits(PTW, MTW, PLW)-1:0]           i_push_data   [0:LEVEL-1],
  input  logic [LEVEL-1:0]                              i_pop_valid,
  output logic [LEVEL-1:0]                              o_pop_ready,
  input  logic [tree_bits(TREE_NUM)-1:0]                i_pop_treeId  [0:LEVEL-1],
  input  logic [LEVEL-1:0]                              i_task_pop,
  output logic [task_bits(PTW, MTW, PLW, TREE_NUM)-1:0] o_task_data   [0:LEVEL-1],
  output logic [LEVEL-1:0]                              o_task_empty,
  output logic [cnt_bits(FIFO_DEPTH)-1:0]               o_task_count  [0:LEVEL-1]
);

  for (genvar g = 0; g < LEVEL; g++) begin : g_lane
    task_enqueue_lane #(
      .DataBits (data_bits(PTW, MTW, PLW)),
      .TreeBits (tree_bits(TREE_NUM)),
      .Depth    (FIFO_DEPTH),
      .MergeWait(MERGE_WAIT),
      .TaskBits (task_bits(PTW, MTW, PLW, TREE_NUM)),
      .CntBits  (cnt_bits(FIFO_DEPTH))
    ) u_lane (
      .clk_i       (i_clk),
      .rst_i       (i_rst),
      .push_valid_i(i_push_valid[g]),
      .push_ready_o(o_push_ready[g]),
      .push_tree_i (i_push_treeId[g]),
      .push_data_i (i_push_data[g]),
      .pop_valid_i (i_pop_valid[g]),
      .pop_ready_o (o_pop_ready[g]),
      .pop_tree_i  (i_pop_treeId[g]),
      .task_pop_i  (i_task_pop[g]),
      .task_data_o (o_task_data[g]),
      .task_empty_o(o_task_empty[g]),
      .task_count_o(o_task_count[g])
    );
  end

endmodule

// File: tb/tb_task_enqueue.sv
// Scoreboard bench for task_enqueue; expectations follow TASK_ENQUEUE_MERGE_EN.
module tb_task_enqueue;

  localparam int unsigned L     = 4;
  localparam int unsigned TB    = 2;
  localparam int unsigned DB    = 40;
  localparam int unsigned KB    = 46;
  localparam int unsigned CW    = 5;
  localparam int unsigned MW    = 4;
  localparam int unsigned DEPTH = 16;
`ifdef TASK_ENQUEUE_MERGE_EN
  localparam bit Merge = 1'b1;
`else
  localparam bit Merge = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [L-1:0]  push_valid, push_ready, pop_valid, pop_ready, task_pop, task_empty;
  logic [TB-1:0] push_tree [0:L-1];
  logic [DB-1:0] push_data [0:L-1];
  logic [TB-1:0] pop_tree  [0:L-1];
  logic [KB-1:0] task_data [0:L-1];
  logic [CW-1:0] task_count [0:L-1];

  logic [KB-1:0] exp_q [L][$];
  logic [KB-1:0] last_word [L];
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  task_enqueue #(
    .PTW(16), .MTW(16), .PLW(8), .LEVEL(L), .TREE_NUM(4),
    .FIFO_DEPTH(DEPTH), .MERGE_WAIT(MW)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_push_valid (push_valid),
    .o_push_ready (push_ready),
    .i_push_treeId(push_tree),
    .i_push_data  (push_data),
    .i_pop_valid  (pop_valid),
    .o_pop_ready  (pop_ready),
    .i_pop_treeId (pop_tree),
    .i_task_pop   (task_pop),
    .o_task_data  (task_data),
    .o_task_empty (task_empty),
    .o_task_count (task_count)
  );

  function automatic logic [KB-1:0] word(bit pu, bit po, logic [TB-1:0] pt, logic [TB-1:0] qt,
                                         logic [DB-1:0] d);
    return {pu, po, pt, qt, d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    push_valid = '0;
    pop_valid  = '0;
    task_pop   = '0;
    for (int l = 0; l < L; l++) begin
      push_tree[l] = '0;
      push_data[l] = '0;
      pop_tree[l]  = '0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    n_tests++;
    if (push_ready !== 4'h0 || pop_ready !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_readies: push=%b pop=%b want 0000/0000", push_ready, pop_ready);
    end
    rst = 1'b0;
    tick();
    n_tests++;
    if (task_empty !== 4'hF) begin
      n_fail++;
      $display("FAIL reset_empty: got %b want 1111", task_empty);
    end
    for (int l = 0; l < L; l++) begin
      n_tests++;
      if (task_count[l] !== 5'd0 || task_data[l] !== '0) begin
        n_fail++;
        $display("FAIL reset_state lane %0d: count=%0d data=%h want 0/0", l, task_count[l],
                 task_data[l]);
      end
    end
    n_tests++;
    if (push_ready !== 4'hF || pop_ready !== 4'hF) begin
      n_fail++;
      $display("FAIL post_reset_readies: push=%b pop=%b want 1111/1111", push_ready, pop_ready);
    end
  endtask

  task automatic test_push_only();
    int lat;
    lat = Merge ? MW : 0;
    push_valid[0] = 1'b1;
    push_tree[0]  = 2'd2;
    push_data[0]  = 40'h123456789A;
    #1;
    n_tests++;
    if (push_ready[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL push_only_ready: got %b want 1", push_ready[0]);
    end
    tick();
    push_valid[0] = 1'b0;
    exp_q[0].push_back(word(1'b1, 1'b0, 2'd2, 2'd0, 40'h123456789A));
    for (int k = 0; k < lat; k++) begin
      n_tests++;
      if (task_empty[0] !== 1'b1 || push_ready[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL push_hold k=%0d: empty=%b push_ready=%b want 1/0", k, task_empty[0],
                 push_ready[0]);
      end
      tick();
    end
    n_tests++;
    if (task_empty[0] !== 1'b0 || task_count[0] !== 5'd1) begin
      n_fail++;
      $display("FAIL push_only_written: empty=%b count=%0d want 0/1", task_empty[0],
               task_count[0]);
    end
  endtask

  task automatic test_same_cycle();
    logic [DB-1:0] d;
    d = 40'hCAFE000111;
    push_valid[1] = 1'b1;
    push_tree[1]  = 2'd1;
    push_data[1]  = d;
    pop_valid[1]  = 1'b1;
    pop_tree[1]   = 2'd3;
    #1;
    n_tests++;
    if (push_ready[1] !== 1'b1 || pop_ready[1] !== Merge) begin
      n_fail++;
      $display("FAIL same_cycle_ready: push=%b pop=%b want 1/%b", push_ready[1], pop_ready[1],
               Merge);
    end
    tick();
    push_valid[1] = 1'b0;
    pop_valid[1]  = !Merge;
    tick();
    pop_valid[1]  = 1'b0;
    if (Merge) begin
      exp_q[1].push_back(word(1'b1, 1'b1, 2'd1, 2'd3, d));
    end else begin
      exp_q[1].push_back(word(1'b1, 1'b0, 2'd1, 2'd0, d));
      exp_q[1].push_back(word(1'b0, 1'b1, 2'd0, 2'd3, '0));
    end
    n_tests++;
    if (task_count[1] !== (Merge ? 5'd1 : 5'd2)) begin
      n_fail++;
      $display("FAIL same_cycle_count: got %0d want %0d", task_count[1], Merge ? 1 : 2);
    end
  endtask

  task automatic test_merge_window();
    logic [DB-1:0] d;
    d = 40'h00BEEF2222;
    pop_valid[2] = 1'b1;
    pop_tree[2]  = 2'd0;
    #1;
    tick();
    pop_valid[2] = 1'b0;
    #1;
    n_tests++;
    if (pop_ready[2] !== !Merge || task_empty[2] !== Merge) begin
      n_fail++;
      $display("FAIL merge_hold: pop_ready=%b empty=%b want %b/%b", pop_ready[2],
               task_empty[2], !Merge, Merge);
    end
    tick();
    push_valid[2] = 1'b1;
    push_tree[2]  = 2'd2;
    push_data[2]  = d;
    #1;
    n_tests++;
    if (push_ready[2] !== 1'b1) begin
      n_fail++;
      $display("FAIL merge_push_ready: got %b want 1", push_ready[2]);
    end
    tick();
    push_valid[2] = 1'b0;
    if (Merge) begin
      exp_q[2].push_back(word(1'b1, 1'b1, 2'd2, 2'd0, d));
    end else begin
      exp_q[2].push_back(word(1'b0, 1'b1, 2'd0, 2'd0, '0));
      exp_q[2].push_back(word(1'b1, 1'b0, 2'd2, 2'd0, d));
    end
    n_tests++;
    if (task_count[2] !== (Merge ? 5'd1 : 5'd2)) begin
      n_fail++;
      $display("FAIL merge_count: got %0d want %0d", task_count[2], Merge ? 1 : 2);
    end
  endtask

  task automatic test_drain();
    logic [KB-1:0] exp_w;
    for (int l = 0; l < L; l++) begin
      int guard;
      guard = 0;
      while (exp_q[l].size() != 0 && guard < 40) begin
        n_tests++;
        if (task_empty[l] !== 1'b0) begin
          n_fail++;
          $display("FAIL drain_nonempty lane %0d: empty=%b want 0", l, task_empty[l]);
        end
        task_pop[l] = 1'b1;
        tick();
        task_pop[l] = 1'b0;
        exp_w = exp_q[l].pop_front();
        last_word[l] = exp_w;
        n_tests++;
        if (task_data[l] !== exp_w) begin
          n_fail++;
          $display("FAIL drain_data lane %0d: got %h want %h", l, task_data[l], exp_w);
        end
        guard++;
      end
      n_tests++;
      if (task_empty[l] !== 1'b1 || task_count[l] !== 5'd0) begin
        n_fail++;
        $display("FAIL drain_end lane %0d: empty=%b count=%0d want 1/0", l, task_empty[l],
                 task_count[l]);
      end
    end
  endtask

  task automatic test_full();
    int acc, guard;
    logic [KB-1:0] exp_w;
    acc = 0;
    guard = 0;
    push_valid[3] = 1'b1;
    pop_valid[3]  = Merge;
    while (acc < DEPTH && guard < 40) begin
      push_tree[3] = acc[1:0];
      pop_tree[3]  = ~acc[1:0];
      push_data[3] = 40'h5A00000000 + 40'(acc);
      #1;
      if (push_ready[3]) begin
        exp_q[3].push_back(word(1'b1, Merge, acc[1:0], Merge ? ~acc[1:0] : 2'd0,
                                40'h5A00000000 + 40'(acc)));
        acc++;
      end
      tick();
      guard++;
    end
    push_data[3] = 40'h5AFFFFFFFF;
    push_tree[3] = 2'd3;
    pop_tree[3]  = 2'd1;
    #1;
    n_tests++;
    if (task_count[3] !== 5'd16 || push_ready[3] !== 1'b0 || pop_ready[3] !== 1'b0) begin
      n_fail++;
      $display("FAIL full_state: count=%0d push_ready=%b pop_ready=%b want 16/0/0",
               task_count[3], push_ready[3], pop_ready[3]);
    end
    task_pop[3] = 1'b1;
    #1;
    n_tests++;
    if (push_ready[3] !== 1'b0) begin
      n_fail++;
      $display("FAIL full_read_same_cycle: push_ready=%b want 0", push_ready[3]);
    end
    tick();
    task_pop[3] = 1'b0;
    exp_w = exp_q[3].pop_front();
    last_word[3] = exp_w;
    n_tests++;
    if (task_data[3] !== exp_w) begin
      n_fail++;
      $display("FAIL full_head: got %h want %h", task_data[3], exp_w);
    end
    n_tests++;
    if (push_ready[3] !== 1'b1) begin
      n_fail++;
      $display("FAIL full_reopen: push_ready=%b want 1", push_ready[3]);
    end
    exp_q[3].push_back(word(1'b1, Merge, 2'd3, Merge ? 2'd1 : 2'd0, 40'h5AFFFFFFFF));
    tick();
    push_valid[3] = 1'b0;
    pop_valid[3]  = 1'b0;
    n_tests++;
    if (task_count[3] !== 5'd16) begin
      n_fail++;
      $display("FAIL full_17th: count=%0d want 16", task_count[3]);
    end
  endtask

  task automatic test_back_to_back();
    logic [KB-1:0] exp_w;
    push_valid[1] = 1'b1;
    pop_valid[1]  = Merge;
    push_tree[1]  = 2'd0;
    pop_tree[1]   = 2'd2;
    push_data[1]  = 40'h0000B2B000;
    #1;
    tick();
    exp_q[1].push_back(word(1'b1, Merge, 2'd0, Merge ? 2'd2 : 2'd0, 40'h0000B2B000));
    for (int i = 1; i <= 4; i++) begin
      task_pop[1]  = 1'b1;
      push_tree[1] = 2'(i);
      push_data[1] = 40'h0000B2B000 + 40'(i);
      #1;
      tick();
      exp_q[1].push_back(word(1'b1, Merge, 2'(i), Merge ? 2'd2 : 2'd0,
                              40'h0000B2B000 + 40'(i)));
      exp_w = exp_q[1].pop_front();
      last_word[1] = exp_w;
      n_tests++;
      if (task_data[1] !== exp_w || task_count[1] !== 5'd1) begin
        n_fail++;
        $display("FAIL b2b i=%0d: data=%h count=%0d want %h/1", i, task_data[1],
                 task_count[1], exp_w);
      end
    end
    task_pop[1]   = 1'b0;
    push_valid[1] = 1'b0;
    pop_valid[1]  = 1'b0;
  endtask

  task automatic test_empty_pop();
    task_pop[0] = 1'b1;
    tick();
    task_pop[0] = 1'b0;
    n_tests++;
    if (task_data[0] !== last_word[0] || task_count[0] !== 5'd0 || task_empty[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL empty_pop: data=%h count=%0d empty=%b want %h/0/1", task_data[0],
               task_count[0], task_empty[0], last_word[0]);
    end
  endtask

  task automatic test_reset_hold();
    push_valid[2] = 1'b1;
    push_tree[2]  = 2'd1;
    push_data[2]  = 40'h7777777777;
    #1;
    tick();
    push_valid[2] = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < MW + 2; k++) tick();
    for (int l = 0; l < L; l++) last_word[l] = '0;
    n_tests++;
    if (task_empty[2] !== 1'b1 || task_count[2] !== 5'd0 || task_data[2] !== '0) begin
      n_fail++;
      $display("FAIL reset_hold: empty=%b count=%0d data=%h want 1/0/0", task_empty[2],
               task_count[2], task_data[2]);
    end
  endtask

  initial begin
    test_reset();
    test_push_only();
    test_same_cycle();
    test_merge_window();
    test_drain();
    test_full();
    test_drain();
    test_back_to_back();
    test_drain();
    test_empty_pop();
    test_reset_hold();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
